// File: rtl/fadd_align_pipe.sv
// Floating-point adder alignment stage: picks the larger-magnitude operand, right-shifts the
// smaller significand with guard/round/sticky, registers the result. `FADD_ALIGN_SKID_EN adds a skid entry.
module fadd_align_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   clrn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MAN_W:0]         large_frac,
   output logic [MAN_W+3:0]       small_frac,
   output logic [EXP_W-1:0]       temp_exp,
   output logic                   sign,
   output logic                   op_sub,
   output logic                   s_is_nan,
   output logic                   s_is_inf,
   output logic [MAN_W-1:0]       inf_nan_frac
);
   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned SF_W  = MAN_W + 4;
   localparam int unsigned WIN_W = 2 * MAN_W + 4;
   localparam int unsigned PAY_W = (MAN_W + 1) + SF_W + EXP_W + 4 + MAN_W;

   logic                   exchange_c;
   logic [W-1:0]           large_c, small_c;
   logic [EXP_W-1:0]       l_exp_c, s_exp_c, shift_c;
   logic [MAN_W:0]         l_sig_c, s_sig_c;
   logic                   l_inf_c, l_nan_c, s_inf_c, s_nan_c;
   logic                   sign_c, op_sub_c, nan_c, inf_c;
   logic [WIN_W-1:0]       win_c;
   logic [SF_W-1:0]        small_frac_c;
   logic [MAN_W-2:0]       nan_max_c;
   logic [MAN_W-1:0]       inf_nan_frac_c;
   logic [PAY_W-1:0]       pay_c;
   logic                   accept_c;

   // Operand ordering, special-case classification and alignment shift.
   always_comb begin
      exchange_c = b[W-2:0] > a[W-2:0];
      large_c    = exchange_c ? b : a;
      small_c    = exchange_c ? a : b;
      l_exp_c    = large_c[W-2:MAN_W];
      s_exp_c    = small_c[W-2:MAN_W];
      l_sig_c    = {|l_exp_c, large_c[MAN_W-1:0]};
      s_sig_c    = {|s_exp_c, small_c[MAN_W-1:0]};

      l_inf_c    = (&l_exp_c) & ~(|large_c[MAN_W-1:0]);
      l_nan_c    = (&l_exp_c) &  (|large_c[MAN_W-1:0]);
      s_inf_c    = (&s_exp_c) & ~(|small_c[MAN_W-1:0]);
      s_nan_c    = (&s_exp_c) &  (|small_c[MAN_W-1:0]);

      sign_c     = exchange_c ? (sub ^ b[W-1]) : a[W-1];
      op_sub_c   = sub ^ large_c[W-1] ^ small_c[W-1];
      inf_c      = l_inf_c | s_inf_c;
      nan_c      = l_nan_c | s_nan_c | (op_sub_c & l_inf_c & s_inf_c);
      nan_max_c  = (a[MAN_W-2:0] > b[MAN_W-2:0]) ? a[MAN_W-2:0] : b[MAN_W-2:0];
      inf_nan_frac_c = nan_c ? {1'b1, nan_max_c} : '0;

      // A denormal smaller operand has an effective exponent of 1, not 0.
      shift_c = l_exp_c - s_exp_c - EXP_W'((l_exp_c != '0) && (s_exp_c == '0));
      if (32'(shift_c) >= 32'(MAN_W + 3)) begin
         win_c = WIN_W'(s_sig_c);
      end else begin
         win_c = {s_sig_c, {(MAN_W + 3){1'b0}}} >> shift_c;
      end
      small_frac_c = {win_c[WIN_W-1 -: (MAN_W + 3)], |win_c[MAN_W:0]};

      pay_c = {l_sig_c, small_frac_c, l_exp_c, sign_c, op_sub_c, nan_c, inf_c, inf_nan_frac_c};
   end

   logic [PAY_W-1:0] head_q, head_d;
   logic             head_v_q, head_v_d;

   assign out_valid = head_v_q;
   assign {large_frac, small_frac, temp_exp, sign, op_sub, s_is_nan, s_is_inf, inf_nan_frac} = head_q;

`ifdef FADD_ALIGN_SKID_EN
   logic [PAY_W-1:0] skid_q, skid_d;
   logic             skid_v_q, skid_v_d;
   logic             pop_c;

   assign in_ready = ~skid_v_q;
   assign accept_c = in_valid & in_ready;
   assign pop_c    = head_v_q & out_ready;

   // Two-entry queue: head drives the outputs, skid catches the beat accepted during a stall.
   always_comb begin
      head_d   = head_q;
      head_v_d = head_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (!head_v_q) begin
         if (accept_c) begin
            head_d   = pay_c;
            head_v_d = 1'b1;
         end
      end else if (pop_c) begin
         if (skid_v_q) begin
            head_d   = skid_q;
            skid_v_d = 1'b0;
         end else if (accept_c) begin
            head_d   = pay_c;
         end else begin
            head_v_d = 1'b0;
         end
      end else if (accept_c) begin
         skid_d   = pay_c;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         skid_q   <= '0;
         skid_v_q <= 1'b0;
      end else begin
         skid_q   <= skid_d;
         skid_v_q <= skid_v_d;
      end
   end
`else
   assign in_ready = ~head_v_q | out_ready;
   assign accept_c = in_valid & in_ready;

   // Single output register; a push in the same cycle as a pop replaces the old beat.
   always_comb begin
      head_d   = head_q;
      head_v_d = head_v_q;
      if (accept_c) begin
         head_d   = pay_c;
         head_v_d = 1'b1;
      end else if (out_ready) begin
         head_v_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         head_q   <= '0;
         head_v_q <= 1'b0;
      end else begin
         head_q   <= head_d;
         head_v_q <= head_v_d;
      end
   end

endmodule

// File: tb/tb_fadd_align_pipe.sv
// Directed testbench for fadd_align_pipe at single-precision defaults.
module tb_fadd_align_pipe;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned RW    = (MAN_W + 1) + (MAN_W + 4) + EXP_W + 4 + MAN_W;

   logic               clk, clrn, in_valid, in_ready, sub, out_valid, out_ready;
   logic [W-1:0]       a, b;
   logic [MAN_W:0]     large_frac;
   logic [MAN_W+3:0]   small_frac;
   logic [EXP_W-1:0]   temp_exp;
   logic               sign, op_sub, s_is_nan, s_is_inf;
   logic [MAN_W-1:0]   inf_nan_frac;
   logic [RW-1:0]      res_w;

   int n_checks = 0;
   int n_fail   = 0;

   fadd_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .large_frac(large_frac), .small_frac(small_frac), .temp_exp(temp_exp),
      .sign(sign), .op_sub(op_sub), .s_is_nan(s_is_nan), .s_is_inf(s_is_inf),
      .inf_nan_frac(inf_nan_frac)
   );

   assign res_w = {large_frac, small_frac, temp_exp, sign, op_sub, s_is_nan, s_is_inf, inf_nan_frac};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] pk(input logic [23:0] lf, input logic [26:0] sf,
                                        input logic [7:0] e, input logic s, input logic o,
                                        input logic n, input logic i, input logic [22:0] f);
      return {lf, sf, e, s, o, n, i, f};
   endfunction

   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv);
      a = av; b = bv; sub = sv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 'x; b = 'x; sub = 1'bx;
   endtask

   task automatic test_reset();
      clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 'x; b = 'x; sub = 1'bx;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || res_w !== '0) begin
         $display("FAIL reset_state: out_valid=%b data=%h, want 0 and 0", out_valid, res_w); n_fail++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_in_ready: got %b want 1", in_ready); n_fail++;
      end
      @(negedge clk); clrn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || res_w !== '0) begin
         $display("FAIL idle_x_inputs: out_valid=%b data=%h, want 0 and 0", out_valid, res_w); n_fail++;
      end
   endtask

   task automatic test_add();
      logic [31:0]   va [5];
      logic [31:0]   vb [5];
      logic          vs [5];
      logic [RW-1:0] ve [5];
      va = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h00000000};
      vb = '{32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h3F800000, 32'h00000000};
      vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ve = '{pk(24'h800000, 27'h4000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h2000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h2000000, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h2000000, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0),
             pk(24'h000000, 27'h0000000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0)};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(va[i], vb[i], vs[i]);
         n_checks++;
         if (out_valid !== 1'b1 || res_w !== ve[i]) begin
            $display("FAIL add_vec%0d: valid=%b data=%h want valid=1 data=%h", i, out_valid, res_w, ve[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_shift();
      logic [31:0]   va [4];
      logic [31:0]   vb [4];
      logic [RW-1:0] ve [4];
      va = '{32'h4B800000, 32'h00800000, 32'h4C000000, 32'h4C800000};
      vb = '{32'h3F800001, 32'h00000001, 32'h3F800000, 32'h3F800000};
      ve = '{pk(24'h800000, 27'h0000005, 8'h97, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h0000008, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h0000002, 8'h98, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h0000001, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0)};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(va[i], vb[i], 1'b0);
         n_checks++;
         if (out_valid !== 1'b1 || res_w !== ve[i]) begin
            $display("FAIL shift_vec%0d: valid=%b data=%h want valid=1 data=%h", i, out_valid, res_w, ve[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_special();
      logic [31:0]   va [4];
      logic [31:0]   vb [4];
      logic          vs [4];
      logic [RW-1:0] ve [4];
      va = '{32'h7F800000, 32'h7FC00001, 32'h3F800000, 32'h7F800000};
      vb = '{32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h7F800000};
      vs = '{1'b1, 1'b0, 1'b0, 1'b0};
      ve = '{pk(24'h800000, 27'h4000000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 23'h400000),
             pk(24'hC00001, 27'h0000001, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 23'h400001),
             pk(24'h800000, 27'h0000001, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 23'h0),
             pk(24'h800000, 27'h4000000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 23'h0)};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(va[i], vb[i], vs[i]);
         n_checks++;
         if (out_valid !== 1'b1 || res_w !== ve[i]) begin
            $display("FAIL special_vec%0d: valid=%b data=%h want valid=1 data=%h", i, out_valid, res_w, ve[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0]   va [3];
      logic [31:0]   vb [3];
      logic          vs [3];
      logic [RW-1:0] ve [3];
      va = '{32'h3F800000, 32'h4B800000, 32'h7F800000};
      vb = '{32'h3F800000, 32'h3F800001, 32'h7F800000};
      vs = '{1'b0, 1'b0, 1'b1};
      ve = '{pk(24'h800000, 27'h4000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h0000005, 8'h97, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0),
             pk(24'h800000, 27'h4000000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 23'h400000)};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = va[i]; b = vb[i]; sub = vs[i]; in_valid = 1'b1;
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || res_w !== ve[i] || in_ready !== 1'b1) begin
            $display("FAIL b2b_beat%0d: valid=%b rdy=%b data=%h want 1 1 %h", i, out_valid, in_ready, res_w, ve[i]);
            n_fail++;
         end
      end
      in_valid = 1'b0; a = 'x; b = 'x; sub = 1'bx;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL b2b_drain: out_valid=%b want 0", out_valid); n_fail++;
      end
   endtask

   task automatic test_backpressure();
      logic [RW-1:0] ea, eb, r0, r1;
      logic          acc;
      int            got;
      ea = pk(24'h800000, 27'h4000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0);
      eb = pk(24'h800000, 27'h0000008, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0);
      r0 = '0; r1 = '0; got = 0;
      out_ready = 1'b0;
      send(32'h3F800000, 32'h3F800000, 1'b0);
      a = 32'h00800000; b = 32'h00000001; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         acc = in_valid & in_ready;
         n_checks++;
         if (out_valid !== 1'b1 || res_w !== ea) begin
            $display("FAIL stall_hold%0d: valid=%b data=%h want 1 %h", i, out_valid, res_w, ea); n_fail++;
         end
         if (i == 2) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
               $display("FAIL stall_in_ready: got %b want 0", in_ready); n_fail++;
            end
         end
         @(posedge clk); #1;
         if (acc) begin in_valid = 1'b0; a = 'x; b = 'x; sub = 1'bx; end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid) begin
            if (got == 0) r0 = res_w; else if (got == 1) r1 = res_w;
            got++;
         end
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) begin in_valid = 1'b0; a = 'x; b = 'x; sub = 1'bx; end
      end
      n_checks++;
      if (got != 2 || r0 !== ea || r1 !== eb) begin
         $display("FAIL drain_order: beats=%0d first=%h second=%h want 2 %h %h", got, r0, r1, ea, eb);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_stall();
      out_ready = 1'b0;
      send(32'h4B800000, 32'h3F800001, 1'b0);
      @(posedge clk); #2;
      clrn = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || res_w !== '0) begin
         $display("FAIL stall_reset: valid=%b data=%h want 0 and 0", out_valid, res_w); n_fail++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL stall_reset_rdy: got %b want 1", in_ready); n_fail++;
      end
      @(negedge clk); clrn = 1'b1;
      out_ready = 1'b1;
      send(32'h3F800000, 32'h3F000000, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || res_w !== pk(24'h800000, 27'h2000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0)) begin
         $display("FAIL post_reset_beat: valid=%b data=%h", out_valid, res_w); n_fail++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL post_reset_drain: out_valid=%b want 0", out_valid); n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_shift();
      test_special();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
